// File: rtl/mac_pkg.sv
// ============================================================================
// Module   : mac_pkg
// Brief    : Shared FSM encoding and saturation limits for the MAC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

    localparam int MAC_N = 25;
    localparam int MAC_W = 2 * MAC_N;

    // Saturation limits at the default 2N-bit width
    localparam logic [MAC_W-1:0] MAX_POS = {1'b0, {(MAC_W-1){1'b1}}};
    localparam logic [MAC_W-1:0] MIN_NEG = {1'b1, {(MAC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        ACC   = 3'd3,
        DONE  = 3'd4
    } mac_state_e;

endpackage

`default_nettype wire

// File: rtl/mac_sequencer_if.sv
// ============================================================================
// Module   : mac_sequencer_if
// Brief    : Control and arithmetic-datapath signals of the MAC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mac_sequencer_if #(
    parameter int N  = 25,
    parameter int AW = 3
);
    logic             start;
    logic [2*N-1:0]   Multiplica;
    logic [2*N-1:0]   Suma_G;
    logic [2*N-1:0]   Sum_ext;
    logic [AW-1:0]    tap_addr;
    logic             mul_en;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   result;
    logic             ovf;

    modport master (
        output start, Multiplica, Suma_G,
        input  Sum_ext, tap_addr, mul_en, busy, done, result, ovf
    );

    modport slave (
        input  start, Multiplica, Suma_G,
        output Sum_ext, tap_addr, mul_en, busy, done, result, ovf
    );
endinterface

`default_nettype wire

// File: rtl/mac_ovf_detect.sv
// ============================================================================
// Module   : mac_ovf_detect
// Brief    : Signed-add overflow flag and saturated replacement value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_ovf_detect #(
    parameter int W = 50
) (
    input  wire logic [W-1:0] i_sum_ext,
    input  wire logic [W-1:0] i_multiplica,
    input  wire logic [W-1:0] i_suma_g,
    output logic              o_ovf,
    output logic [W-1:0]      o_sat_val
);

    logic w_unused_bits;

    // Same-sign operands producing an opposite-sign sum
    assign o_ovf = (i_sum_ext[W-1] == i_multiplica[W-1]) &&
                   (i_suma_g[W-1]  != i_sum_ext[W-1]);

    assign o_sat_val = i_multiplica[W-1] ? {1'b1, {(W-1){1'b0}}}
                                         : {1'b0, {(W-1){1'b1}}};

    assign w_unused_bits = ^{i_sum_ext[W-2:0], i_multiplica[W-2:0], i_suma_g[W-2:0]};

endmodule

`default_nettype wire

// File: rtl/mac_sequencer.sv
// ============================================================================
// Module   : mac_sequencer
// Brief    : Sequences a TAPS-long multiply-accumulate over a shared adder.
//            Optional MAC_SAT_EN: saturate the accumulator on signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_sequencer
    import mac_pkg::*;
#(
    parameter int N    = 25,
    parameter int TAPS = 5,
    parameter int AW   = 3
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    mac_sequencer_if.slave  bus
);

    localparam int           W          = 2 * N;
    localparam logic [AW-1:0] C_LAST_TAP = AW'(TAPS - 1);

    mac_state_e     r_state;
    mac_state_e     w_state_next;
    logic [W-1:0]   r_sum_ext;
    logic [AW-1:0]  r_tap_addr;
    logic [W-1:0]   r_result;
    logic           r_ovf;
    logic           w_mul_en;
    logic           w_busy;
    logic           w_done;
    logic           w_last_tap;
    logic           w_ovf;
    logic [W-1:0]   w_sat_val;
    logic [W-1:0]   w_acc_val;

    mac_ovf_detect #(.W(W)) u_ovf_detect (
        .i_sum_ext    (r_sum_ext),
        .i_multiplica (bus.Multiplica),
        .i_suma_g     (bus.Suma_G),
        .o_ovf        (w_ovf),
        .o_sat_val    (w_sat_val)
    );

`ifdef MAC_SAT_EN
    assign w_acc_val = w_ovf ? w_sat_val : bus.Suma_G;
`else
    logic w_unused_sat;
    assign w_unused_sat = ^w_sat_val;
    assign w_acc_val    = bus.Suma_G;
`endif

    assign w_last_tap = (r_tap_addr == C_LAST_TAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mul_en     = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (bus.start) w_state_next = CLEAR;
            end
            CLEAR: w_state_next = FETCH;
            FETCH: begin
                w_mul_en     = 1'b1;
                w_state_next = ACC;
            end
            ACC:   w_state_next = w_last_tap ? DONE : FETCH;
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_ext  <= '0;
            r_tap_addr <= '0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_sum_ext  <= '0;
                    r_tap_addr <= '0;
                    r_ovf      <= 1'b0;
                end
                ACC: begin
                    r_sum_ext <= w_acc_val;
                    if (w_ovf) r_ovf <= 1'b1;
                    if (w_last_tap) begin
                        r_result <= w_acc_val;
                    end else begin
                        r_tap_addr <= r_tap_addr + 1'b1;
                    end
                end
                DONE:    r_tap_addr <= '0;
                default: ;
            endcase
        end
    end

    assign bus.Sum_ext  = r_sum_ext;
    assign bus.tap_addr = r_tap_addr;
    assign bus.result   = r_result;
    assign bus.ovf      = r_ovf;
    assign bus.mul_en   = w_mul_en;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;

endmodule

`default_nettype wire

// File: tb/tb_mac_sequencer.sv
// ============================================================================
// Module   : tb_mac_sequencer
// Brief    : Directed self-checking bench for mac_sequencer (adder modelled here).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_sequencer;
    import mac_pkg::*;

    localparam int N    = 25;
    localparam int TAPS = 5;
    localparam int AW   = 3;
    localparam int W    = 2 * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [W-1:0] prod [0:7];

    always #5 clk = ~clk;

    mac_sequencer_if #(.N(N), .AW(AW)) bus ();

    mac_sequencer #(.N(N), .TAPS(TAPS), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always_comb bus.Multiplica = prod[bus.tap_addr];
    assign bus.Suma_G = bus.Sum_ext + bus.Multiplica;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [W-1:0] p0, p1, p2, p3, p4);
        prod[0] = p0; prod[1] = p1; prod[2] = p2; prod[3] = p3; prod[4] = p4;
        prod[5] = '0; prod[6] = '0; prod[7] = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"},    64'(bus.busy),     64'd0);
        check_val({tag, "_done"},    64'(bus.done),     64'd0);
        check_val({tag, "_mul_en"},  64'(bus.mul_en),   64'd0);
        check_val({tag, "_tap"},     64'(bus.tap_addr), 64'd0);
        check_val({tag, "_sum_ext"}, 64'(bus.Sum_ext),  64'd0);
        check_val({tag, "_result"},  64'(bus.result),   64'd0);
        check_val({tag, "_ovf"},     64'(bus.ovf),      64'd0);
    endtask

    // Called at a negedge with the DUT in IDLE; start is sampled on the next
    // posedge, which makes the first following negedge cycle 1 (CLEAR).
    task automatic run_mac(input string tag, input logic [W-1:0] exp_res,
                           input logic exp_ovf, input bit hold, input int pulse_at);
        int dones   = 0;
        int done_c  = 0;
        int fetches = 0;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = hold;
        for (int c = 1; c <= 3 + 2 * TAPS; c++) begin
            @(negedge clk);
            if (c == pulse_at)     bus.start = 1'b1;
            if (c == pulse_at + 1) bus.start = 1'b0;
            if (bus.mul_en) begin
                check_val({tag, "_fetch_tap"}, 64'(bus.tap_addr), 64'(fetches));
                fetches++;
            end
            if (bus.done) begin
                dones++;
                done_c = c;
                check_val({tag, "_result"},  64'(bus.result),  64'(exp_res));
                check_val({tag, "_sum_ext"}, 64'(bus.Sum_ext), 64'(exp_res));
                check_val({tag, "_ovf"},     64'(bus.ovf),     64'(exp_ovf));
            end
            if (c == 2 + 2 * TAPS) check_val({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
            if (c == 3 + 2 * TAPS) check_val({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
        end
        check_val({tag, "_done_count"}, 64'(dones),   64'd1);
        check_val({tag, "_done_cycle"}, 64'(done_c),  64'(2 + 2 * TAPS));
        check_val({tag, "_fetches"},    64'(fetches), 64'(TAPS));
    endtask

    logic [W-1:0] exp_ovf_res;
    int           rst_dones;
    bit           found;

    initial begin
`ifdef MAC_SAT_EN
        exp_ovf_res = MAX_POS;
`else
        exp_ovf_res = MIN_NEG;
`endif
        bus.start = 1'b0;
        load('0, '0, '0, '0, '0);
        #1 check_idle_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        load(1, 2, 3, 4, 5);
        run_mac("basic", 15, 1'b0, 1'b0, 0);

        load(-7, 3, -1, 0, 2);
        run_mac("signed", -3, 1'b0, 1'b0, 0);

        load(MAX_POS, 1, 0, 0, 0);
        run_mac("overflow", exp_ovf_res, 1'b1, 1'b0, 0);

        // Abort during the third ACC: tap_addr==2 with mul_en low
        load(1, 2, 3, 4, 5);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (bus.busy && !bus.mul_en && bus.tap_addr == 3'd2) found = 1'b1;
        end
        check_val("rst_reach_acc2", 64'(found), 64'd1);
        check_val("rst_sum_before", 64'(bus.Sum_ext), 64'd3);
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("midrun_rst");
        rst_dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) rst_dones++;
        end
        check_val("rst_no_done", 64'(rst_dones), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_mac("post_rst", 15, 1'b0, 1'b0, 0);

        // Extra start during FETCH of tap 2 (cycle 6) must be ignored
        load(5, 5, 5, 5, 5);
        run_mac("busy_ignore", 25, 1'b0, 1'b0, 6);
        repeat (4) begin
            @(negedge clk);
            check_val("busy_ignore_stays_idle", 64'(bus.busy), 64'd0);
        end

        // Back-to-back with start held: overflow run then a clean run
        load(MAX_POS, 1, 0, 0, 0);
        run_mac("b2b_first", exp_ovf_res, 1'b1, 1'b1, 0);
        load(10, -20, 30, -40, 50);
        run_mac("b2b_second", 30, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
